// File: rtl/sync_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_debounce_pkg
// Description : Shared constants and helpers for the sync_debounce conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_debounce_pkg;

    // Smallest legal synchronizer depth and filter length.
    localparam int c_MIN_N             = 2;
    localparam int c_MIN_FILTER_CYCLES = 1;

    // The filter counter must hold 0 .. FILTER_CYCLES-1.
    // Sizing it for FILTER_CYCLES keeps it at least one bit wide when FILTER_CYCLES == 1.
    function automatic int cnt_width(input int filter_cycles);
        return $clog2(filter_cycles + 1);
    endfunction

endpackage : sync_debounce_pkg
`default_nettype wire

// File: rtl/sync_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : sync_debounce_channel
// Description : One channel: N-deep synchronizer, stability filter, edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce_channel
    import sync_debounce_pkg::*;
#(
    parameter int N             = 2,
    parameter int FILTER_CYCLES = 4,
    parameter bit RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_out,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam int              CNT_W      = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    (* ASYNC_REG = "TRUE" *) logic [N-1:0] r_sync;

    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_rise;
    logic             r_fall;

    logic w_sync;
    logic w_differ;
    logic w_accept;

    // Pure register chain: nothing may sit between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {N{RESET_BIT}};
        end else begin
            r_sync <= {r_sync[N-2:0], i_in};
        end
    end

    assign w_sync   = r_sync[N-1];
    assign w_differ = (w_sync != r_out);
    assign w_accept = w_differ && (r_cnt == c_CNT_LAST);

    // Any return to the current level during counting drops the partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_out  <= RESET_BIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept &&  w_sync;
            r_fall <= w_accept && !w_sync;
            if (w_accept) begin
                r_out <= w_sync;
                r_cnt <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_out  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_busy = w_differ;

endmodule : sync_debounce_channel
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sync_debounce
// Description : Multi-channel synchronizer + debounce + rise/fall pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               N             = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    generate
        if (N < c_MIN_N) begin : g_bad_n
            $error("sync_debounce: N must be at least 2");
        end
        if (FILTER_CYCLES < c_MIN_FILTER_CYCLES) begin : g_bad_filter
            $error("sync_debounce: FILTER_CYCLES must be at least 1");
        end
    endgenerate

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_channel
            sync_debounce_channel #(
                .N             (N),
                .FILTER_CYCLES (FILTER_CYCLES),
                .RESET_BIT     (RESET_VALUE[i])
            ) u_channel (
                .clk    (clk),
                .rst    (rst),
                .i_in   (in[i]),
                .o_out  (out[i]),
                .o_rise (rise[i]),
                .o_fall (fall[i]),
                .o_busy (busy[i])
            );
        end
    endgenerate

endmodule : sync_debounce
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_debounce
// Description : Self-checking bench for sync_debounce against a history-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_debounce;

    localparam int         W    = 2;
    localparam int         N    = 2;
    localparam int         F    = 4;
    localparam logic [W-1:0] RV = 2'b10;
    localparam int         MAXT = 8192;

    logic         clk;
    logic         d_rst;
    logic [W-1:0] d_in;
    logic [W-1:0] out, rise, fall, busy;

    int n_vec = 0;
    int n_err = 0;

    sync_debounce #(
        .WIDTH         (W),
        .N             (N),
        .FILTER_CYCLES (F),
        .RESET_VALUE   (RV)
    ) dut (
        .clk  (clk),
        .rst  (d_rst),
        .in   (d_in),
        .out  (out),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per-edge histories of inputs, resets, synchronized values and outputs.
    logic [W-1:0] in_h [MAXT];
    bit           rst_h[MAXT];
    logic [W-1:0] s_h  [MAXT];
    logic [W-1:0] o_h  [MAXT];
    int           t = 0;
    logic [W-1:0] m_out, m_rise, m_fall, m_busy;

    function automatic logic [W-1:0] s_at(input int idx);
        return (idx < 1) ? RV : s_h[idx];
    endfunction

    // Drive one cycle of stimulus and advance the model to the state after that edge.
    task automatic tick(input logic [W-1:0] v, input bit r);
        bit           rs;
        bit           all_diff;
        logic [W-1:0] o_prev;
        logic [W-1:0] sv;
        d_in  = v;
        d_rst = r;
        @(posedge clk);
        t++;
        if (t >= MAXT) begin
            $display("FAIL model_overflow: t=%0d limit=%0d", t, MAXT);
            $fatal(1);
        end
        in_h[t]  = v;
        rst_h[t] = r;
        // The synchronizer output is the input seen N-1 edges ago, unless a reset intervened.
        rs = 1'b0;
        for (int k = 0; k < N; k++)
            if ((t - k) < 1 || rst_h[t-k]) rs = 1'b1;
        s_h[t] = rs ? RV : in_h[t-N+1];
        o_prev = (t < 2) ? RV : o_h[t-1];
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (r) begin
                m_out[i] = RV[i];
            end else begin
                // Output follows once the last F synchronized values all disagree with it.
                all_diff = 1'b1;
                for (int k = 1; k <= F; k++) begin
                    sv = s_at(t - k);
                    if (sv[i] == o_prev[i]) all_diff = 1'b0;
                end
                m_out[i]  = all_diff ? ~o_prev[i] : o_prev[i];
                m_rise[i] = all_diff && !o_prev[i];
                m_fall[i] = all_diff &&  o_prev[i];
            end
        end
        o_h[t] = m_out;
        m_busy = s_h[t] ^ m_out;
        #1;
    endtask

    task automatic test_reset();
        int nfall1, at;
        for (int c = 0; c < 3; c++) begin
            tick(2'b00, 1'b1);
            n_vec++;
            if ({out, rise, fall, busy} !== {RV, 2'b00, 2'b00, 2'b00}) begin
                n_err++;
                $display("FAIL reset_hold c=%0d: got out=%b rise=%b fall=%b busy=%b, want out=%b others 0",
                         c, out, rise, fall, busy, RV);
            end
        end
        nfall1 = 0; at = -1;
        for (int c = 1; c <= 10; c++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL reset_release c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
            if (fall[1] === 1'b1) begin nfall1++; at = c; end
        end
        n_vec++;
        if (nfall1 != 1 || at != N + F || out !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release_pulse: got count=%0d edge=%0d out=%b want count=1 edge=%0d out=00",
                     nfall1, at, out, N + F);
        end
    endtask

    task automatic test_latency();
        int nrise, at, nbusy;
        for (int c = 0; c < 10; c++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL latency_settle c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
        end
        nrise = 0; at = -1; nbusy = 0;
        for (int c = 1; c <= 10; c++) begin
            tick(2'b01, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL latency c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
            if (rise[0] === 1'b1) begin nrise++; at = c; end
            if (busy[0] === 1'b1) nbusy++;
        end
        n_vec++;
        if (nrise != 1 || at != N + F || nbusy != F || out[0] !== 1'b1) begin
            n_err++;
            $display("FAIL latency_edge: got rise_count=%0d edge=%0d busy_cycles=%0d out0=%b want 1 %0d %0d 1",
                     nrise, at, nbusy, out[0], N + F, F);
        end
    endtask

    task automatic test_glitch();
        int nrise, nbusy;
        for (int c = 0; c < 10; c++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL glitch_settle c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
        end
        nrise = 0; nbusy = 0;
        for (int c = 1; c <= 12; c++) begin
            tick((c <= F - 1) ? 2'b01 : 2'b00, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL glitch c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
            if (rise[0] === 1'b1 || out[0] !== 1'b0) nrise++;
            if (busy[0] === 1'b1) nbusy++;
        end
        n_vec++;
        if (nrise != 0 || nbusy != F - 1) begin
            n_err++;
            $display("FAIL glitch_reject: got bad_cycles=%0d busy_cycles=%0d want 0 %0d", nrise, nbusy, F - 1);
        end
    endtask

    task automatic test_boundary();
        int rat, fat, nr, nf;
        for (int c = 0; c < 10; c++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL boundary_settle c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
        end
        rat = -1; fat = -1; nr = 0; nf = 0;
        for (int c = 1; c <= 16; c++) begin
            tick((c <= F) ? 2'b01 : 2'b00, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL boundary c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
            if (rise[0] === 1'b1) begin nr++; rat = c; end
            if (fall[0] === 1'b1) begin nf++; fat = c; end
        end
        n_vec++;
        if (nr != 1 || nf != 1 || rat != N + F || fat != N + 2 * F) begin
            n_err++;
            $display("FAIL boundary_accept: got rise=%0d@%0d fall=%0d@%0d want 1@%0d 1@%0d",
                     nr, rat, nf, fat, N + F, N + 2 * F);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] v;
        int r0, r1, n0, n1;
        for (int c = 0; c < 10; c++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL simul_settle c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
        end
        r0 = -1; r1 = -1; n0 = 0; n1 = 0;
        for (int c = 1; c <= 16; c++) begin
            v = (c == 2 || c == 4) ? 2'b01 : 2'b11;
            tick(v, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL simul c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
            if (rise[0] === 1'b1) begin n0++; r0 = c; end
            if (rise[1] === 1'b1) begin n1++; r1 = c; end
        end
        // Channel 1 last changed at cycle 5, so it settles F cycles after that change propagates.
        n_vec++;
        if (n0 != 1 || n1 != 1 || r0 != N + F || r1 != 5 + N - 1 + F) begin
            n_err++;
            $display("FAIL simul_pulses: got ch0=%0d@%0d ch1=%0d@%0d want 1@%0d 1@%0d",
                     n0, r0, n1, r1, N + F, 5 + N - 1 + F);
        end
    endtask

    task automatic test_reset_mid();
        int r0, f1, bad;
        for (int c = 0; c < 10; c++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL rstmid_settle c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
        end
        bad = 0;
        for (int c = 1; c <= 5; c++) begin
            tick(2'b01, (c == 5));
            if (rise !== 2'b00 || fall !== 2'b00) bad++;
        end
        n_vec++;
        if (bad != 0 || out !== RV || busy !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_clear: got out=%b busy=%b pulses=%0d want out=%b busy=00 pulses=0",
                     out, busy, bad, RV);
        end
        r0 = -1; f1 = -1;
        for (int c = 1; c <= 10; c++) begin
            tick(2'b01, 1'b0);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL rstmid c=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
            if (rise[0] === 1'b1) r0 = c;
            if (fall[1] === 1'b1) f1 = c;
        end
        n_vec++;
        if (r0 != N + F || f1 != N + F) begin
            n_err++;
            $display("FAIL rstmid_latency: got rise0@%0d fall1@%0d want both @%0d", r0, f1, N + F);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        int           hold;
        bit           r;
        v = 2'b00;
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                v    = W'($urandom_range(0, 3));
                hold = $urandom_range(1, 2 * F + 2);
            end
            hold--;
            r = ($urandom_range(0, 199) == 0);
            tick(v, r);
            n_vec++;
            if ({out, rise, fall, busy} !== {m_out, m_rise, m_fall, m_busy}) begin
                n_err++;
                $display("FAIL random c=%0d in=%b rst=%0d: got %b_%b_%b_%b want %b_%b_%b_%b",
                         c, v, r, out, rise, fall, busy, m_out, m_rise, m_fall, m_busy);
            end
        end
    endtask

    initial begin
        d_in  = 2'b00;
        d_rst = 1'b1;
        test_reset();
        test_latency();
        test_glitch();
        test_boundary();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sync_debounce
`default_nettype wire
